// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl
//   Bridges a single-request valid/ready port onto an asynchronous 16-bit
//   SRAM. Generates active-low write/output-enable strobes, the address and
//   a tri-stated data bus. Read data comes back on a one-cycle response pulse.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        asynchronous, active-low reset
//   req_valid    request present
//   req_ready    controller idle; accept on req_valid && req_ready at clk edge
//   req_we       1 = write, 0 = read
//   req_addr     request address
//   req_wdata    write data
//   rsp_valid    one-cycle pulse, rsp_rdata valid
//   rsp_rdata    read data, held until next read response
//   mem_addr     SRAM address (holds last value while idle)
//   mem_we       SRAM write strobe, active-low
//   mem_oe       SRAM output enable, active-low
//   mem_data_io  SRAM data bus, driven only during write states
module sram_req_ctrl #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int TURN_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    inout  wire  [DATA_W-1:0] mem_data_io
);

    // A zero dwell would collapse a phase, so each is clamped to at least 1.
    localparam int SETUP_N  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int STROBE_N = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
    localparam int TURN_N   = (TURN_CYCLES   < 1) ? 1 : TURN_CYCLES;
    localparam int MAX_ST   = (SETUP_N > STROBE_N) ? SETUP_N : STROBE_N;
    localparam int MAX_N    = (MAX_ST > TURN_N) ? MAX_ST : TURN_N;
    localparam int CNT_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_N - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_SETUP,
        S_R_STROBE,
        S_R_TURN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_last;
    logic              w_accept;
    logic              w_rsp_nxt;
    logic              w_drive_nxt;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_we;
    logic              r_mem_oe;
    logic              r_drive;

    // Dwell counter counts down to zero; the state advances on the zero cycle.
    assign w_last = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = req_we ? S_W_SETUP : S_R_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
            S_W_SETUP: begin
                if (w_last) begin
                    w_state_nxt = S_W_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_W_STROBE: begin
                if (w_last) begin
                    w_state_nxt = S_W_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_W_HOLD: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            S_R_SETUP: begin
                if (w_last) begin
                    w_state_nxt = S_R_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_R_STROBE: begin
                if (w_last) begin
                    w_state_nxt = S_R_TURN;
                    w_cnt_nxt   = TURN_LD;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_R_TURN: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they belong to while staying free of combinational paths.
    assign w_rsp_nxt   = (r_state == S_R_STROBE) && w_last;
    assign w_drive_nxt = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_STROBE) ||
                         (w_state_nxt == S_W_HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_mem_we    <= 1'b1;
            r_mem_oe    <= 1'b1;
            r_drive     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= w_rsp_nxt;
            r_mem_we    <= (w_state_nxt != S_W_STROBE);
            r_mem_oe    <= (w_state_nxt != S_R_STROBE);
            r_drive     <= w_drive_nxt;
            if (w_accept) begin
                r_mem_addr <= req_addr;
                r_wdata    <= req_wdata;
            end
            // Memory has been driving the bus for the whole strobe; capture
            // on the edge that ends it.
            if (w_rsp_nxt) begin
                r_rsp_rdata <= mem_data_io;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_oe      = r_mem_oe;
    assign mem_data_io = r_drive ? r_wdata : {DATA_W{1'bz}};

endmodule
